// File: rtl/dou_float_div.sv
// Iterative IEEE-754 double divider: 55-cycle radix-2 restoring mantissa divide,
// then a single normalise/round/range-check cycle, behind valid/ready handshakes.
module dou_float_div #(
    parameter int EXP_BIAS = 1023,
    parameter int DIV_BITS = 55
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ina,
    input  logic [63:0] inb,
    input  logic        round_cfg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic [1:0]  defectornon_signal
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    localparam logic signed [12:0] EXP_MAX = 13'sd2047;
    localparam logic signed [12:0] EXP_MIN = 13'sd0;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic                  rc_q, rc_d;
    logic [12:0]           exp_q, exp_d;
    logic [53:0]           rem_q, rem_d;
    logic [52:0]           div_q, div_d;
    logic [DIV_BITS-1:0]   q_q, q_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [63:0]           out_q, out_d;
    logic [1:0]            stat_q, stat_d;

    // Borrow in bit 54 means rem < div.
    logic [54:0] sub_w;
    assign sub_w = {1'b0, rem_q} - {2'b00, div_q};

    logic [51:0] mant_a;
    logic        guard;
    logic [12:0] exp_a, exp_f;
    logic [52:0] mant_r;

    always_comb begin
        if (q_q[DIV_BITS-1]) begin
            mant_a = q_q[DIV_BITS-2 -: 52];
            guard  = q_q[DIV_BITS-54];
            exp_a  = exp_q;
        end else begin
            mant_a = q_q[DIV_BITS-3 -: 52];
            guard  = q_q[DIV_BITS-55];
            exp_a  = exp_q - 13'd1;
        end
        // A carry out leaves mant_r[51:0] all zero, which is the required mantissa.
        mant_r = {1'b0, mant_a} + {52'h0, rc_q & guard};
        exp_f  = exp_a + {12'h0, mant_r[52]};
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        rc_d    = rc_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = ina[63] ^ inb[63];
                    rc_d   = round_cfg;
                    exp_d  = {2'b00, ina[62:52]} - {2'b00, inb[62:52]} + 13'(EXP_BIAS);
                    rem_d  = {2'b01, ina[51:0]};
                    div_d  = {1'b1, inb[51:0]};
                    q_d    = '0;
                    cnt_d  = '0;
                    if (inb[62:52] == 11'h0) begin
                        out_d   = {ina[63] ^ inb[63], 11'h7FF, 52'h0};
                        stat_d  = 2'b11;
                        state_d = S_DONE;
                    end else if (ina[62:52] == 11'h0) begin
                        out_d   = {ina[63] ^ inb[63], 63'h0};
                        stat_d  = 2'b00;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (!sub_w[54]) begin
                    rem_d = sub_w[53:0] << 1;
                    q_d   = {q_q[DIV_BITS-2:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    q_d   = {q_q[DIV_BITS-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DIV_BITS - 1))
                    state_d = S_NORM;
            end
            S_NORM: begin
                if ($signed(exp_f) >= EXP_MAX) begin
                    out_d  = {sign_q, 11'h7FF, 52'h0};
                    stat_d = 2'b01;
                end else if ($signed(exp_f) <= EXP_MIN) begin
                    out_d  = {sign_q, 63'h0};
                    stat_d = 2'b10;
                end else begin
                    out_d  = {sign_q, exp_f[10:0], mant_r[51:0]};
                    stat_d = 2'b00;
                end
                exp_d   = exp_f;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            rc_q    <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            stat_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            rc_q    <= rc_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            stat_q  <= stat_d;
        end
    end

    assign in_ready           = (state_q == S_IDLE);
    assign out_valid          = (state_q == S_DONE);
    assign out                = out_q;
    assign defectornon_signal = stat_q;

endmodule

// File: tb/tb_dou_float_div.sv
// Self-checking bench for dou_float_div: directed cases plus randomized operands
// compared against an integer-division reference of the quotient rules.
module tb_dou_float_div;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ina = '0;
    logic [63:0] inb = '0;
    logic        round_cfg = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out;
    logic [1:0]  defectornon_signal;

    int n_vec = 0;
    int n_err = 0;

    dou_float_div dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .round_cfg(round_cfg), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .defectornon_signal(defectornon_signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {status, quotient}; the mantissa quotient comes from one wide integer divide.
    function automatic logic [65:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic rc);
        logic s;
        int ea, eb, e;
        logic [127:0] num, den, qq;
        logic [51:0] m;
        logic g;
        s  = a[63] ^ b[63];
        ea = int'(a[62:52]);
        eb = int'(b[62:52]);
        if (eb == 0) return {2'b11, s, 11'h7FF, 52'h0};
        if (ea == 0) return {2'b00, s, 63'h0};
        num = {75'h0, 1'b1, a[51:0]} << 54;
        den = {75'h0, 1'b1, b[51:0]};
        qq  = num / den;
        e   = ea - eb + 1023;
        if (qq[54]) begin m = qq[53:2]; g = qq[1]; end
        else        begin m = qq[52:1]; g = qq[0]; e = e - 1; end
        if (rc && g) begin
            if (&m) begin m = '0; e = e + 1; end
            else m = m + 52'd1;
        end
        if (e >= 2047) return {2'b01, s, 11'h7FF, 52'h0};
        if (e <= 0)    return {2'b10, s, 63'h0};
        return {2'b00, s, e[10:0], m};
    endfunction

    // One operation: accept, measure latency, check result, optionally stall, then take it.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic rc, input int hold,
                          output logic [63:0] got_out, output logic [1:0] got_st);
        logic [65:0] r;
        int n;
        r = ref_div(a, b, rc);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        ina = a; inb = b; round_cfg = rc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), (a[62:52] == 0 || b[62:52] == 0) ? 64'd0 : 64'd56);
        chk({tag, ".out"}, out, r[63:0]);
        chk({tag, ".status"}, 64'(defectornon_signal), 64'(r[65:64]));
        got_out = out;
        got_st  = defectornon_signal;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ina = {$urandom, $urandom}; inb = 64'h0; in_valid = i[0];
            @(posedge clk); #1;
            chk({tag, ".hold_out"}, out, got_out);
            chk({tag, ".hold_hs"}, {62'h0, in_ready, out_valid}, 64'b01);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".take"}, {62'h0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        logic [63:0] o;
        logic [1:0]  st;
        logic [63:0] a, b;
        int ea, eb;

        #1;
        chk("reset.out", out, 64'h0);
        chk("reset.status", 64'(defectornon_signal), 64'h0);
        chk("reset.hs", {62'h0, in_ready, out_valid}, 64'b10);
        @(negedge clk); reset_n = 1'b1;

        run_op("div6_2", 64'h4018000000000000, 64'h4000000000000000, 1'b0, 0, o, st);
        chk("div6_2.const", o, 64'h4008000000000000);
        run_op("div5_3c", 64'h4014000000000000, 64'h4008000000000000, 1'b0, 0, o, st);
        chk("div5_3c.const", o, 64'h3FFAAAAAAAAAAAAA);
        run_op("div5_3r", 64'h4014000000000000, 64'h4008000000000000, 1'b1, 0, o, st);
        chk("div5_3r.const", o, 64'h3FFAAAAAAAAAAAAB);
        run_op("div1_3c", 64'h3FF0000000000000, 64'h4008000000000000, 1'b0, 0, o, st);
        chk("div1_3c.const", o, 64'h3FD5555555555555);
        run_op("div1_3r", 64'h3FF0000000000000, 64'h4008000000000000, 1'b1, 0, o, st);
        chk("div1_3r.const", o, 64'h3FD5555555555555);
        run_op("divzero", 64'hBFF0000000000000, 64'h0, 1'b0, 0, o, st);
        chk("divzero.const", {o, 62'h0, st} >> 62, {o, 62'h0, 2'b11} >> 62);
        chk("divzero.out", o, 64'hFFF0000000000000);
        run_op("zero_num", 64'h8000000000000000, 64'h3FF0000000000000, 1'b0, 0, o, st);
        chk("zero_num.const", o, 64'h8000000000000000);
        run_op("ovf", 64'h7FE0000000000000, 64'h3FE0000000000000, 1'b0, 0, o, st);
        chk("ovf.const", {o[63:0]}, 64'h7FF0000000000000);
        chk("ovf.st", 64'(st), 64'd1);
        run_op("unf", 64'h0010000000000000, 64'h4000000000000000, 1'b0, 0, o, st);
        chk("unf.const", o, 64'h0);
        chk("unf.st", 64'(st), 64'd2);
        run_op("bp", 64'h4014000000000000, 64'h4008000000000000, 1'b1, 10, o, st);
        run_op("after_bp", 64'h4018000000000000, 64'h4000000000000000, 1'b0, 0, o, st);
        chk("after_bp.const", o, 64'h4008000000000000);

        // Reset dropped 20 cycles into a divide.
        @(negedge clk);
        ina = 64'h4014000000000000; inb = 64'h4008000000000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.out", out, 64'h0);
        chk("rst_mid.status", 64'(defectornon_signal), 64'h0);
        chk("rst_mid.hs", {62'h0, in_ready, out_valid}, 64'b10);
        @(negedge clk); reset_n = 1'b1;
        run_op("post_rst", 64'h4018000000000000, 64'h4000000000000000, 1'b0, 0, o, st);
        chk("post_rst.const", o, 64'h4008000000000000);

        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k[0]) begin
                ea = $urandom_range(823, 1223);
                eb = $urandom_range(823, 1223);
            end else begin
                ea = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2047);
                eb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2047);
            end
            a[62:52] = ea[10:0];
            b[62:52] = eb[10:0];
            run_op("rand", a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), o, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
